// File: rtl/dp_share_sched_pkg.sv
// rtl/dp_share_sched_pkg.sv - shared types and constants for the dp_share_sched scheduler
package dp_share_pkg;

  localparam int DEF_W = 16;

  localparam logic [1:0] MODE_PROD = 2'd0;
  localparam logic [1:0] MODE_SQ1  = 2'd1;
  localparam logic [1:0] MODE_SQ2  = 2'd2;
  localparam logic [1:0] MODE_ZERO = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ADD_A,
    ADD_B,
    MUL,
    DONE
  } state_t;

endpackage

// File: rtl/dp_share_sched_seq_mul.sv
// rtl/dp_share_sched_seq_mul.sv - fixed-latency LSB-first shift-add multiplier, (W+1)x(W+1) -> 2W+2
module seq_mul #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W:0]     a,
  input  logic [W:0]     b,
  output logic           busy,
  output logic           done,
  output logic [2*W+1:0] product
);

  localparam int MUL_IT = W + 1;
  localparam int CW     = $clog2(MUL_IT + 1);

  logic [2*W+1:0] mcand;
  logic [2*W+1:0] acc;
  logic [W:0]     mplier;
  logic [CW-1:0]  cnt;

  // Always runs all MUL_IT iterations so latency never depends on operand values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{(W+1){1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(MUL_IT);
      busy   <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

  // High during the cycle whose closing edge performs the final iteration.
  assign done    = busy && (cnt == CW'(1));
  assign product = acc;

endmodule

// File: rtl/dp_share_sched.sv
// rtl/dp_share_sched.sv - schedules out1=in1+in2, out2=in3+in4, out3=mode product on one adder and one multiplier
module dp_share_sched
  import dp_share_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in1,
  input  logic [W-1:0]   in2,
  input  logic [W-1:0]   in3,
  input  logic [W-1:0]   in4,
  input  logic [W-1:0]   in5,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W:0]     out1,
  output logic [W:0]     out2,
  output logic [2*W+1:0] out3,
  output logic           busy
);

  state_t         state, nstate;
  logic [W-1:0]   c1, c2, c3, c4;
  logic [1:0]     mode;
  logic [W-1:0]   add_a, add_b;
  logic [W:0]     add_sum;
  logic [W:0]     mul_a, mul_b;
  logic           mul_start, mul_busy, mul_done;
  logic [2*W+1:0] mul_product;
  logic           unused_bits;

  assign unused_bits = ^{in5[W-1:2], mul_busy};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (in_valid) nstate = ADD_A;
      ADD_A:   nstate = ADD_B;
      ADD_B:   nstate = (mode == MODE_ZERO) ? DONE : MUL;
      MUL:     if (mul_done) nstate = DONE;
      DONE:    if (out_valid && out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    add_a     = (state == ADD_A) ? c1 : c3;
    add_b     = (state == ADD_A) ? c2 : c4;
    mul_start = (state == ADD_B) && (mode != MODE_ZERO);
  end

  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  // out2 is being written on the start edge, so the multiplier takes it straight from the adder.
  assign mul_a = (mode == MODE_SQ2) ? add_sum : out1;
  assign mul_b = (mode == MODE_SQ1) ? out1 : add_sum;

  seq_mul #(.W(W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (mul_a),
    .b       (mul_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c1        <= '0;
      c2        <= '0;
      c3        <= '0;
      c4        <= '0;
      mode      <= MODE_PROD;
      out1      <= '0;
      out2      <= '0;
      out3      <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          c1   <= in1;
          c2   <= in2;
          c3   <= in3;
          c4   <= in4;
          mode <= in5[1:0];
        end
        ADD_A: out1 <= add_sum;
        ADD_B: out2 <= add_sum;
        // First DONE cycle loads out3 and raises out_valid; it then holds until the sink accepts.
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out3      <= (mode == MODE_ZERO) ? '0 : mul_product;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
